// File: rtl/ds1124_serial_ctrl.sv
// ds1124_serial_ctrl: host-side 3-wire serial controller for a DS1124 delay line.
// Writes shift a new tap value out; reads shift the value in and echo it back.
module ds1124_serial_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] delay_value,
   input  logic       en,
   input  logic       read_delay,
   output logic       ready,
   output logic [7:0] current_delay,
   output logic       read_valid,
   output logic       ds1124_clk,
   output logic       ds1124_d,
   output logic       ds1124_e,
   input  logic       ds1124_q
);
   localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SHIFT   = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [1:0] RECOVER = 2'd3;

   if (CLK_DIV < 2) begin : g_bad_div
      $fatal(1, "ds1124_serial_ctrl: CLK_DIV must be >= 2");
   end

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ph_q, ph_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sr_q, sr_d;
   logic          rd_q, rd_d;
   logic          ready_q, ready_d;
   logic          e_q, e_d;
   logic          sclk_q, sclk_d;
   logic          d_q, d_d;
   logic [7:0]    cur_q, cur_d;
   logic          rv_q, rv_d;
   logic          last;

   assign last = cnt_q == CW'(CLK_DIV - 1);

   always_comb begin
      state_d = state_q;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      ph_d    = ph_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      rd_d    = rd_q;
      ready_d = ready_q;
      e_d     = e_q;
      sclk_d  = sclk_q;
      d_d     = d_q;
      cur_d   = cur_q;
      rv_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (ready_q && (en || read_delay)) begin
               state_d = SHIFT;
               ready_d = 1'b0;
               e_d     = 1'b1;
               ph_d    = 1'b0;
               bit_d   = 3'd0;
               rd_d    = !en;
               sr_d    = en ? delay_value : 8'h00;
               d_d     = en ? delay_value[7] : 1'b0;
            end
         end
         SHIFT: begin
            // Read: capture Q early in the low phase and echo it so E-fall restores the value.
            if (rd_q && !ph_q && cnt_q == '0) begin
               sr_d = {sr_q[6:0], ds1124_q};
               d_d  = ds1124_q;
            end
            if (last) begin
               ph_d   = !ph_q;
               sclk_d = !ph_q;
               if (ph_q) begin
                  bit_d = bit_q + 3'd1;
                  if (!rd_q) begin
                     sr_d = {sr_q[6:0], 1'b0};
                     d_d  = sr_q[6];
                  end
                  if (bit_q == 3'd7) state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (last) begin
               state_d = RECOVER;
               e_d     = 1'b0;
               d_d     = 1'b0;
            end
         end
         default: begin
            if (last) begin
               state_d = IDLE;
               ready_d = 1'b1;
               cur_d   = rd_q ? sr_q : cur_q;
               rv_d    = rd_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ph_q    <= 1'b0;
         bit_q   <= 3'd0;
         sr_q    <= 8'h00;
         rd_q    <= 1'b0;
         ready_q <= 1'b1;
         e_q     <= 1'b0;
         sclk_q  <= 1'b0;
         d_q     <= 1'b0;
         cur_q   <= 8'h00;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         rd_q    <= rd_d;
         ready_q <= ready_d;
         e_q     <= e_d;
         sclk_q  <= sclk_d;
         d_q     <= d_d;
         cur_q   <= cur_d;
         rv_q    <= rv_d;
      end
   end

   assign ready         = ready_q;
   assign current_delay = cur_q;
   assign read_valid    = rv_q;
   assign ds1124_clk    = sclk_q;
   assign ds1124_d      = d_q;
   assign ds1124_e      = e_q;
endmodule

// File: tb/tb_ds1124_serial_ctrl.sv
// tb_ds1124_serial_ctrl: table-driven scoreboard bench with a behavioural DS1124 model.
module tb_ds1124_serial_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0, en = 1'b0, rd = 1'b0;
   logic [7:0] val = 8'h00;
   logic       rdy, rv, dc, dd, de, q;
   logic [7:0] cur;
   logic       en2 = 1'b0, rdy2, rv2, c2, d2, e2;
   logic [7:0] val2 = 8'h00, cur2;

   ds1124_serial_ctrl #(.CLK_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .delay_value(val), .en(en), .read_delay(rd),
      .ready(rdy), .current_delay(cur), .read_valid(rv),
      .ds1124_clk(dc), .ds1124_d(dd), .ds1124_e(de), .ds1124_q(q));

   ds1124_serial_ctrl #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .delay_value(val2), .en(en2), .read_delay(1'b0),
      .ready(rdy2), .current_delay(cur2), .read_valid(rv2),
      .ds1124_clk(c2), .ds1124_d(d2), .ds1124_e(e2), .ds1124_q(1'b0));

   // Device model: E rise loads the shift register, CLK rise shifts D in, E fall latches.
   logic [7:0] msr, mval, dev_init = 8'h00;
   logic       dev_load = 1'b0;
   assign q = msr[7];
   always @(posedge de or posedge dc) msr <= dc ? {msr[6:0], dd} : mval;
   always @(negedge de or posedge dev_load) mval <= dev_load ? dev_init : msr;

   int cyc = 0, rl = 0, eh = 0, rvn = 0, rvbad = 0, et = 0, gapbad = 0, lastc = 0;
   logic have = 1'b0, pc = 1'b0, prdy = 1'b1;
   logic [7:0] bits = 8'h00;
   always @(negedge clk) begin
      cyc  <= cyc + 1;
      pc   <= dc;
      prdy <= rdy;
      if (!rdy) rl <= rl + 1;
      if (de) eh <= eh + 1;
      if (rv) rvn <= rvn + 1;
      if (rv && !(rdy && !prdy)) rvbad <= rvbad + 1;
      if (dc && !pc) begin
         et    <= et + 1;
         bits  <= {bits[6:0], dd};
         lastc <= cyc;
         if (have && cyc - lastc != 8) gapbad <= gapbad + 1;
      end
      have <= de && (have || (dc && !pc));
   end

   int rl2 = 0, eh2 = 0, et2 = 0, rvn2 = 0, gap2 = 0, last2 = 0;
   logic have2 = 1'b0, pc2 = 1'b0;
   logic [7:0] bits2 = 8'h00;
   always @(negedge clk) begin
      pc2 <= c2;
      if (!rdy2) rl2 <= rl2 + 1;
      if (e2) eh2 <= eh2 + 1;
      if (rv2) rvn2 <= rvn2 + 1;
      if (c2 && !pc2) begin
         et2   <= et2 + 1;
         bits2 <= {bits2[6:0], d2};
         last2 <= cyc;
         if (have2 && cyc - last2 != 4) gap2 <= gap2 + 1;
      end
      have2 <= e2 && (have2 || (c2 && !pc2));
   end

   typedef struct {
      logic en; logic rd; logic poke; logic load;
      logic [7:0] pre; logic [7:0] val;
      logic [7:0] bits; int rv; logic [7:0] cur; logic [7:0] dev;
   } vec_t;
   typedef struct {
      logic [7:0] bits; int rv; logic [7:0] cur; logic [7:0] dev;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[8];
   vec_t v;
   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic run_txn(input vec_t t);
      int rl0, eh0, rv0, rb0, et0, gb0;
      exp_t x;
      if (t.load) begin
         dev_init = t.pre;
         dev_load = 1'b1;
         #1 dev_load = 1'b0;
      end
      rl0 = rl; eh0 = eh; rv0 = rvn; rb0 = rvbad; et0 = et; gb0 = gapbad;
      @(negedge clk);
      en = t.en; rd = t.rd; val = t.val;
      x = '{t.bits, t.rv, t.cur, t.dev};
      sb.push_back(x);
      @(negedge clk);
      en = 1'b0; rd = 1'b0; val = ~t.val;
      chk("accept_ready_low", rdy, 0);
      if (t.poke) begin
         repeat (10) @(negedge clk);
         en = 1'b1; rd = 1'b1; val = 8'h7E;
         @(negedge clk);
         en = 1'b0; rd = 1'b0;
      end
      for (int i = 0; i < 400 && !rdy; i++) @(negedge clk);
      chk("ready_return", rdy, 1);
      repeat (12) @(negedge clk);
      x = sb.pop_front();
      chk("ready_low_cycles", rl - rl0, 72);
      chk("e_high_cycles", eh - eh0, 68);
      chk("clk_rise_count", et - et0, 8);
      chk("edge_spacing_errors", gapbad - gb0, 0);
      chk("d_at_edges", bits, x.bits);
      chk("read_valid_count", rvn - rv0, x.rv);
      chk("read_valid_alignment", rvbad - rb0, 0);
      chk("current_delay", cur, x.cur);
      chk("device_value", mval, x.dev);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 8'hA5, 0, 8'h00, 8'hA5};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h00, 8'h3C, 1, 8'h3C, 8'h3C};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h5A, 0, 8'h3C, 8'h5A};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 1, 8'h5A, 8'h5A};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 0, 8'h5A, 8'hFF};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 8'h5A, 8'h00};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 8'h81, 0, 8'h00, 8'h81};
      repeat (3) @(negedge clk);
      chk("rst_ready", rdy, 1);
      chk("rst_e", de, 0);
      chk("rst_clk", dc, 0);
      chk("rst_d", dd, 0);
      chk("rst_current_delay", cur, 0);
      chk("rst_read_valid", rv, 0);
      chk("rst_ready_div2", rdy2, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) run_txn(tbl[i]);

      // Reset in the middle of a shift, then confirm normal operation resumes.
      dev_init = 8'hC3; dev_load = 1'b1; #1 dev_load = 1'b0;
      v = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 1, 8'hC3, 8'hC3};
      run_txn(v);
      @(negedge clk);
      en = 1'b1; val = 8'hFF;
      @(negedge clk);
      en = 1'b0;
      repeat (20) @(negedge clk);
      chk("midshift_busy", rdy, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ready", rdy, 1);
      chk("midrst_e", de, 0);
      chk("midrst_clk", dc, 0);
      chk("midrst_d", dd, 0);
      chk("midrst_read_valid", rv, 0);
      chk("midrst_current_delay", cur, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      v = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 8'h96, 0, 8'h00, 8'h96};
      run_txn(v);
      v = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h96, 1, 8'h96, 8'h96};
      run_txn(v);

      // CLK_DIV=2 instance: 36-cycle write.
      begin
         int r0, e0, t0, g0, v0;
         r0 = rl2; e0 = eh2; t0 = et2; g0 = gap2; v0 = rvn2;
         @(negedge clk);
         en2 = 1'b1; val2 = 8'hC3;
         @(negedge clk);
         en2 = 1'b0; val2 = 8'h00;
         chk("div2_accept", rdy2, 0);
         for (int i = 0; i < 200 && !rdy2; i++) @(negedge clk);
         chk("div2_ready_return", rdy2, 1);
         repeat (8) @(negedge clk);
         chk("div2_ready_low_cycles", rl2 - r0, 36);
         chk("div2_e_high_cycles", eh2 - e0, 34);
         chk("div2_clk_rise_count", et2 - t0, 8);
         chk("div2_edge_spacing_errors", gap2 - g0, 0);
         chk("div2_d_at_edges", bits2, 8'hC3);
         chk("div2_read_valid_count", rvn2 - v0, 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
